// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// cpu_pkg : shared widths, reset vector and fetch-state encoding (jacaranda-8)
// Revision: 1.0
// ============================================================================
package cpu_pkg;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned INSTR_W = 8;

  localparam logic [ADDR_W-1:0] RESET_VEC = 8'h00;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_INTR = 1'b1;

  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [INSTR_W-1:0] instr_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/fetch_stage_pc_next.sv
`default_nettype none
// ============================================================================
// pc_next : next-PC select for the fetch stage (jump > reti > intr > inc > hold)
// Revision: 1.0
// ============================================================================
module pc_next #(
  parameter int unsigned ADDR_W = cpu_pkg::ADDR_W
) (
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic [ADDR_W-1:0] ret_addr_i,
  input  logic [ADDR_W-1:0] intr_vec_i,
  input  logic              take_jump_i,
  input  logic              take_reti_i,
  input  logic              take_intr_i,
  input  logic              load_i,
  output logic [ADDR_W-1:0] pc_d_o
);

  always_comb begin
    pc_d_o = pc_i;
    if (take_jump_i) begin
      pc_d_o = jump_addr_i;
    end else if (take_reti_i) begin
      pc_d_o = ret_addr_i;
    end else if (take_intr_i) begin
      pc_d_o = intr_vec_i;
    end else if (load_i) begin
      // Natural modulo wrap: 8'hFF + 1 -> 8'h00.
      pc_d_o = pc_i + ADDR_W'(1);
    end
  end

endmodule : pc_next
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// fetch_stage : PC, instruction register and interrupt entry/return for jacaranda-8
// Revision: 1.0
// ============================================================================
module fetch_stage #(
  parameter int unsigned       ADDR_W    = cpu_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_VEC = cpu_pkg::RESET_VEC
) (
  input  logic                       clock,
  input  logic                       reset_n,
  output logic [ADDR_W-1:0]          instr_addr,
  input  logic [cpu_pkg::INSTR_W-1:0] instr_data,
  output logic [cpu_pkg::INSTR_W-1:0] ir,
  output logic [ADDR_W-1:0]          ir_pc,
  output logic                       ir_valid,
  input  logic                       ir_ready,
  input  logic                       jump_en,
  input  logic [ADDR_W-1:0]          jump_addr,
  input  logic                       reti_en,
  input  logic                       intr_req,
  input  logic [ADDR_W-1:0]          intr_vec,
  output logic                       intr_ack,
  output logic                       in_handler
);

  import cpu_pkg::*;

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  ret_addr_q;
  logic [ADDR_W-1:0]  ir_pc_q;
  logic [INSTR_W-1:0] ir_q;
  logic               ir_valid_q;
  logic               intr_ack_q;
  logic [0:0]         state_q, state_d;

  logic w_load;
  logic w_in_handler;
  logic w_take_reti;
  logic w_take_intr;
  logic w_fetch;

  assign w_load       = !ir_valid_q || ir_ready;
  assign w_in_handler = (state_q == ST_INTR);
  // Jump outranks everything; a reti outside a handler is simply ignored.
  assign w_take_reti  = !jump_en && reti_en && w_in_handler;
  assign w_take_intr  = !jump_en && intr_req && !w_in_handler && w_load;
  assign w_fetch      = !jump_en && !w_take_reti && !w_take_intr && w_load;

  pc_next #(.ADDR_W(ADDR_W)) u_pc_next (
    .pc_i        (pc_q),
    .jump_addr_i (jump_addr),
    .ret_addr_i  (ret_addr_q),
    .intr_vec_i  (intr_vec),
    .take_jump_i (jump_en),
    .take_reti_i (w_take_reti),
    .take_intr_i (w_take_intr),
    .load_i      (w_load),
    .pc_d_o      (pc_d)
  );

  always_comb begin
    state_d = state_q;
    if (w_take_reti) begin
      state_d = ST_RUN;
    end else if (w_take_intr) begin
      state_d = ST_INTR;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q       <= RESET_VEC;
      ir_q       <= '0;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
      ret_addr_q <= '0;
      intr_ack_q <= 1'b0;
      state_q    <= ST_RUN;
    end else begin
      pc_q       <= pc_d;
      state_q    <= state_d;
      intr_ack_q <= w_take_intr;
      if (w_take_intr) begin
        ret_addr_q <= pc_q;
      end
      // Any redirect empties the IR; a stall leaves it untouched.
      if (jump_en || w_take_reti || w_take_intr) begin
        ir_valid_q <= 1'b0;
      end else if (w_fetch) begin
        ir_q       <= instr_data;
        ir_pc_q    <= pc_q;
        ir_valid_q <= 1'b1;
      end
    end
  end

  assign instr_addr = pc_q;
  assign ir         = ir_q;
  assign ir_pc      = ir_pc_q;
  assign ir_valid   = ir_valid_q;
  assign intr_ack   = intr_ack_q;
  assign in_handler = w_in_handler;

endmodule : fetch_stage
`default_nettype wire
